adder_64b: RTL and testbench
============================

Name: adder_64b

Overview:
- Registered 64-bit two's-complement/unsigned adder with carry-in and carry-out.
- Datapath primitive for the ALU; drives the ALU add/sub result mux.
- Subtraction is done upstream by inverting b and setting c_in=1.
- Internal structure: hierarchical carry-lookahead (4-bit groups, group-level lookahead), not a behavioural "+".

Parameters:
- WIDTH, 64, operand/result width; must be a multiple of GROUP_W. Only 64 is required to be verified.
- GROUP_W, 4, bits per carry-lookahead group.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operands on a/b/c_in are valid this cycle.
- c_in, input, 1, carry into bit 0.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- sum, output, WIDTH, registered (a + b + c_in) mod 2^WIDTH.
- c_out, output, 1, registered carry out of bit WIDTH-1.
- out_valid, output, 1, sum/c_out hold a valid result.

Behaviour:
- Reset: rst_n low asynchronously forces sum=0, c_out=0, out_valid=0, and clears any pipeline state. Release is synchronous to the next clk edge.
- Function: {c_out, sum} = a + b + c_in, full WIDTH+1-bit result. No saturation; wrap-around modulo 2^WIDTH.
- Latency: 1 cycle. Operands sampled at edge N appear on sum/c_out after edge N and are stable for the whole next cycle.
- out_valid: equals in_valid delayed by the latency.
- sum/c_out update every cycle regardless of in_valid. Consumers must qualify with out_valid.
- No back-pressure; a new operand set is accepted every cycle (throughput 1/cycle).
- Carry network:
  - Each GROUP_W slice computes per-bit propagate p=a^b, generate g=a&b, group P/G and local sums.
  - Group carries come from a second lookahead level over the 16 groups, with c_in as carry into group 0.
  - sum[i] = p[i] ^ carry[i].
- Boundaries:
  - 0xFFFF_FFFF_FFFF_FFFF + 0 + 1 gives sum=0, c_out=1.
  - Full carry propagation across all 64 bits must complete in one cycle.
- Reset asserted mid-stream: outputs clear immediately. The first result after release corresponds to operands sampled on the first edge with rst_n high.
- X on inputs while in_valid=0 must not corrupt out_valid.

Optional Feature:
- Macro: ADDER_PIPE_EN.
- When defined:
  - Adds a register stage between the lower 32 bits and upper 32 bits.
  - Lower half-sum and carry into bit 32 are registered. Upper operands and in_valid are delayed one cycle to match.
  - Latency 2 cycles, throughput unchanged at 1/cycle.
  - Reset also clears the intermediate stage.
- When undefined: single-stage, 1-cycle latency as above.
- Results must be bit-identical in both builds, only shifted in time.

Decomposition:
- Package adder_pkg holds:
  - localparams ADD_WIDTH=64, ADD_GROUP_W=4, ADD_NUM_GROUPS=ADD_WIDTH/ADD_GROUP_W.
  - typedef word_t (logic [ADD_WIDTH-1:0]).
  - typedef grp_pg_t (struct {p, g}).
- Sub-module cla_group: GROUP_W-bit lookahead cell.
  - Inputs: a, b slice and carry-in.
  - Outputs: slice sum and group P/G.
  - Instantiated ADD_NUM_GROUPS times via generate.
- Top level holds the group-lookahead logic, output registers and the optional pipeline stage.

Test Plan:
- Reset: assert rst_n=0 with random inputs, then release -> sum=0, c_out=0, out_valid=0 during reset; first valid result one latency after release.
- Basic: a=5, b=7, c_in=0 -> sum=12, c_out=0. Same with c_in=1 -> sum=13.
- Full ripple: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, c_in=1 -> sum=0, c_out=1.
- Group boundary: a=64'h0000_0000_FFFF_FFFF, b=1, c_in=0 -> sum=64'h0000_0001_0000_0000, c_out=0. This also checks the ADDER_PIPE_EN split point.
- Max operands: a=b=64'hFFFF_FFFF_FFFF_FFFF, c_in=1 -> sum=64'hFFFF_FFFF_FFFF_FFFF, c_out=1.
- Random streaming: 1000 back-to-back vectors, one per cycle, with in_valid toggled randomly -> every out_valid result matches a reference 65-bit model at the correct latency in both macro builds, zero mismatches.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and sizing for the carry-lookahead adder.
// Group propagate/generate pairs and the prefix operator that merges them.
package adder_pkg;

  localparam int ADD_WIDTH      = 64;
  localparam int ADD_GROUP_W    = 4;
  localparam int ADD_NUM_GROUPS = ADD_WIDTH / ADD_GROUP_W;

  typedef logic [ADD_WIDTH-1:0] word_t;

  typedef struct packed {
    logic p;
    logic g;
  } grp_pg_t;

  // Merge a more-significant span (hi) onto a less-significant span (lo).
  function automatic grp_pg_t pg_combine(input grp_pg_t hi, input grp_pg_t lo);
    grp_pg_t res;
    res.p = hi.p & lo.p;
    res.g = hi.g | (hi.p & lo.g);
    return res;
  endfunction

endpackage

// File: rtl/adder_64b_cla_group.sv
// GROUP_W-bit carry-lookahead cell: local sums from a carry-in plus the
// group propagate/generate pair used by the next lookahead level.
module cla_group
  import adder_pkg::*;
#(
  parameter int GROUP_W = ADD_GROUP_W
) (
  input  logic [GROUP_W-1:0] i_a,
  input  logic [GROUP_W-1:0] i_b,
  input  logic               i_c,
  output logic [GROUP_W-1:0] o_sum,
  output grp_pg_t            o_pg
);

  logic [GROUP_W-1:0] w_p;
  logic [GROUP_W-1:0] w_g;
  logic [GROUP_W-1:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Each bit's carry is the prefix P/G of the bits below it applied to i_c.
  always_comb begin : carry_chain
    grp_pg_t acc;
    grp_pg_t bit_pg;
    // NOTE: every output of a combinational block gets a value before any
    // conditional/loop logic; a path that skips an assignment infers a latch.
    acc.p  = 1'b1;
    acc.g  = 1'b0;
    bit_pg = '0;
    w_c    = '0;
    o_pg   = '0;
    for (int i = 0; i < GROUP_W; i++) begin
      w_c[i]   = acc.g | (acc.p & i_c);
      bit_pg.p = w_p[i];
      bit_pg.g = w_g[i];
      acc      = pg_combine(bit_pg, acc);
    end
    o_pg = acc;
  end

  assign o_sum = w_p ^ w_c;

endmodule

// File: rtl/adder_64b.sv
// Registered WIDTH-bit adder built from cla_group cells and a group-level
// lookahead. Define ADDER_PIPE_EN to register the lower half (latency 2).
module adder_64b
  import adder_pkg::*;
#(
  parameter int WIDTH   = ADD_WIDTH,
  parameter int GROUP_W = ADD_GROUP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             out_valid
);

  localparam int NUM_GROUPS  = WIDTH / GROUP_W;
  localparam int HALF_GROUPS = NUM_GROUPS / 2;
  localparam int HALF_W      = WIDTH / 2;

  logic [WIDTH-1:0]       w_a_grp;
  logic [WIDTH-1:0]       w_b_grp;
  logic [WIDTH-1:0]       w_sum_comb;
  logic [WIDTH-1:0]       w_sum_out;
  grp_pg_t                w_pg [NUM_GROUPS];
  logic [HALF_GROUPS-1:0] w_gc_lo;
  logic [HALF_GROUPS-1:0] w_gc_hi;
  logic                   w_c_mid;
  logic                   w_c_hi_in;
  logic                   w_c_top;
  logic                   w_valid_stage;

  for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_grp
    logic w_c_grp;
    if (k < HALF_GROUPS) begin : g_lo
      assign w_c_grp = w_gc_lo[k];
    end else begin : g_hi
      assign w_c_grp = w_gc_hi[k-HALF_GROUPS];
    end
    cla_group #(.GROUP_W(GROUP_W)) u_cla (
      .i_a   (w_a_grp[k*GROUP_W +: GROUP_W]),
      .i_b   (w_b_grp[k*GROUP_W +: GROUP_W]),
      .i_c   (w_c_grp),
      .o_sum (w_sum_comb[k*GROUP_W +: GROUP_W]),
      .o_pg  (w_pg[k])
    );
  end

  // Lower-half group carries, seeded by c_in; w_c_mid is the carry into bit HALF_W.
  always_comb begin : lo_lookahead
    grp_pg_t acc;
    acc.p   = 1'b1;
    acc.g   = 1'b0;
    w_gc_lo = '0;
    for (int k = 0; k < HALF_GROUPS; k++) begin
      w_gc_lo[k] = acc.g | (acc.p & c_in);
      acc        = pg_combine(w_pg[k], acc);
    end
    w_c_mid = acc.g | (acc.p & c_in);
  end

  // Upper-half group carries, seeded by the (possibly registered) mid carry.
  always_comb begin : hi_lookahead
    grp_pg_t acc;
    acc.p   = 1'b1;
    acc.g   = 1'b0;
    w_gc_hi = '0;
    for (int k = 0; k < HALF_GROUPS; k++) begin
      w_gc_hi[k] = acc.g | (acc.p & w_c_hi_in);
      acc        = pg_combine(w_pg[HALF_GROUPS+k], acc);
    end
    w_c_top = acc.g | (acc.p & w_c_hi_in);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  // NOTE: all registers here are small flops, so each takes the async reset;
  // results and out_valid must read zero the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      c_out     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      sum       <= w_sum_out;
      c_out     <= w_c_top;
      out_valid <= w_valid_stage;
    end
  end

`ifdef ADDER_PIPE_EN
  logic [HALF_W-1:0] r_a_hi;
  logic [HALF_W-1:0] r_b_hi;
  logic [HALF_W-1:0] r_sum_lo;
  logic              r_c_mid;
  logic              r_valid_mid;

  // Upper operands wait one cycle to meet their registered lower-half carry.
  assign w_a_grp       = {r_a_hi, a[HALF_W-1:0]};
  assign w_b_grp       = {r_b_hi, b[HALF_W-1:0]};
  assign w_c_hi_in     = r_c_mid;
  assign w_sum_out     = {w_sum_comb[WIDTH-1:HALF_W], r_sum_lo};
  assign w_valid_stage = r_valid_mid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_hi      <= '0;
      r_b_hi      <= '0;
      r_sum_lo    <= '0;
      r_c_mid     <= 1'b0;
      r_valid_mid <= 1'b0;
    end else begin
      r_a_hi      <= a[WIDTH-1:HALF_W];
      r_b_hi      <= b[WIDTH-1:HALF_W];
      r_sum_lo    <= w_sum_comb[HALF_W-1:0];
      r_c_mid     <= w_c_mid;
      r_valid_mid <= in_valid;
    end
  end
`else
  assign w_a_grp       = a;
  assign w_b_grp       = b;
  assign w_c_hi_in     = w_c_mid;
  assign w_sum_out     = w_sum_comb;
  assign w_valid_stage = in_valid;
`endif

endmodule

// File: tb/tb_adder_64b.sv
// Scoreboard bench for adder_64b; expected {c_out,sum} queued at drive time,
// popped LAT edges later. Build with ADDER_PIPE_EN to check the 2-cycle variant.
module tb_adder_64b;
  import adder_pkg::*;

`ifdef ADDER_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    string      tag;
    logic       v;
    logic [64:0] r;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  in_valid;
  logic  c_in;
  word_t a;
  word_t b;
  word_t sum;
  logic  c_out;
  logic  out_valid;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  adder_64b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .c_in      (c_in),
    .a         (a),
    .b         (b),
    .sum       (sum),
    .c_out     (c_out),
    .out_valid (out_valid)
  );

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [64:0] ref_add(input word_t x, input word_t y, input logic c);
    return {1'b0, x} + {1'b0, y} + {64'd0, c};
  endfunction

  function automatic word_t rand_word();
    return {$urandom(), $urandom()};
  endfunction

  // Drive one operand set, advance one edge, compare whatever has matured.
  task automatic step(input string tag, input logic v, input word_t ia, input word_t ib,
                      input logic ic, input logic [64:0] exp);
    exp_t e;
    in_valid = v;
    a        = ia;
    b        = ib;
    c_in     = ic;
    e.tag    = tag;
    e.v      = v;
    e.r      = exp;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == LAT) begin
      e = q.pop_front();
      check({e.tag, "_valid"}, {64'd0, out_valid}, {64'd0, e.v});
      if (e.v) check(e.tag, {c_out, sum}, e.r);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_sum"},   {1'b0, sum},      65'd0);
    check({tag, "_c_out"}, {64'd0, c_out},   65'd0);
    check({tag, "_valid"}, {64'd0, out_valid}, 65'd0);
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    check_cleared("midrst_async");
    q.delete();
    in_valid = 1'b1;
    a        = rand_word();
    b        = rand_word();
    c_in     = 1'($urandom());
    @(posedge clk);
    #1;
    check_cleared("midrst_held");
    rst_n = 1'b1;
  endtask

  initial begin
    word_t ra;
    word_t rb;
    logic  rc;
    logic  rv;

    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = rand_word();
    b        = rand_word();
    c_in     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    rst_n = 1'b1;

    step("basic",      1'b1, 64'd5, 64'd7, 1'b0, {1'b0, 64'd12});
    step("basic_cin",  1'b1, 64'd5, 64'd7, 1'b1, {1'b0, 64'd13});
    step("full_rip",   1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, {1'b1, 64'd0});
    step("grp_bound",  1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0,
         {1'b0, 64'h0000_0001_0000_0000});
    step("max_ops",    1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
         {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
    step("idle",       1'b0, 64'd3, 64'd4, 1'b0, 65'd0);
    step("msb_ovf",    1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
         {1'b1, 64'd0});
    step("mid_carry",  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 1'b1,
         {1'b0, 64'h0000_0001_0000_0001});

    for (int i = 0; i < 1000; i++) begin
      if (i == 500) mid_reset();
      rv = 1'($urandom_range(0, 1));
      ra = rand_word();
      case ($urandom_range(0, 3))
        0:       rb = ~ra;
        1:       rb = word_t'(1) << $urandom_range(0, 63);
        default: rb = rand_word();
      endcase
      rc = 1'($urandom());
      step("rand", rv, ra, rb, rc, ref_add(ra, rb, rc));
    end

    for (int i = 0; i < LAT; i++) step("drain", 1'b0, rand_word(), rand_word(), 1'b0, 65'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
